// File: rtl/alu_op_sequencer_if.sv
// Command handshake bundle between a command source and alu_op_sequencer.
// The source holds the fields stable with cmd_valid high until cmd_ready is seen.
interface alu_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic       cmd_use_carry;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
               cmd_imm_en, cmd_imm, cmd_use_carry,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
               cmd_imm_en, cmd_imm, cmd_use_carry,
        output cmd_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Three-state sequencer wrapping an external combinational 8-bit ALU:
// operand fetch from a 4x8 register file, registered ALU drive, result writeback and flags.
module alu_op_sequencer (
    input  logic                      clk,
    input  logic                      rst,
    alu_op_sequencer_if.slave         cmd,
    output logic [7:0]                alu_x,
    output logic [7:0]                alu_y,
    output logic [3:0]                alu_cntrl,
    output logic                      alu_c_in,
    input  logic [7:0]                alu_out,
    input  logic                      alu_c_out,
    output logic                      done,
    output logic [7:0]                result,
    output logic                      flag_c,
    output logic                      flag_z,
    input  logic [1:0]                dbg_addr,
    output logic [7:0]                dbg_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       vld_p0;
    logic       vld_p1;
    logic [1:0] rd_p1;
    logic [7:0] regs [4];

    // Only the arithmetic codes (add/sub and their variants) own the carry flag.
    function automatic logic carry_op(input logic [3:0] code);
        logic hit;
        case (code)
            4'b0000, 4'b0001, 4'b1000, 4'b1001: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cmd.cmd_ready = 1'b0;
        done          = 1'b0;
        vld_p0        = 1'b0;
        vld_p1        = 1'b0;
        case (state)
            IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    vld_p0    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                vld_p1    = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: operand and carry-in capture at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_x     <= 8'h00;
            alu_y     <= 8'h00;
            alu_cntrl <= 4'h0;
            alu_c_in  <= 1'b0;
            rd_p1     <= 2'd0;
        end else if (vld_p0) begin
            alu_x     <= regs[cmd.cmd_rs1];
            alu_y     <= cmd.cmd_imm_en ? cmd.cmd_imm : regs[cmd.cmd_rs2];
            alu_cntrl <= cmd.cmd_op;
            alu_c_in  <= cmd.cmd_use_carry & flag_c;
            rd_p1     <= cmd.cmd_rd;
        end
    end

    // p1 -> p2: ALU result writeback and flag update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
            result <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (vld_p1) begin
            regs[rd_p1] <= alu_out;
            result      <= alu_out;
            flag_z      <= (alu_out == 8'h00);
            if (carry_op(alu_cntrl)) flag_c <= alu_c_out;
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule
